// File: rtl/sensor_hub_if.sv
// Sensor-hub stream bundle: per-channel sample inputs plus the merged result stream.
// Ports: sensor_input/sensor_valid (samples in), out_data/out_ch/out_alarm/out_valid (result out),
//        out_ready (downstream ready). master = hub side, slave = producer/consumer side.
interface sensor_hub_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_W-1:0] sensor_input;
    logic [NUM_CH-1:0]        sensor_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_alarm;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  sensor_input, sensor_valid, out_ready,
        output out_data, out_ch, out_alarm, out_valid
    );

    modport slave (
        output sensor_input, sensor_valid, out_ready,
        input  out_data, out_ch, out_alarm, out_valid
    );
endinterface

// File: rtl/sensor_hub.sv
// Purpose: per-channel block averaging of 2^AVG_LOG2 samples, round-robin merge onto one stream.
// Latency: final sample accepted at edge E -> out_valid high after edge E+1.
// Backpressure: out_ready low holds the output beat; one pending slot per channel, overwrite sets overflow.
// Ports: clk, reset_n (async active-low), enable, threshold, overflow_clr, overflow, bus (sensor_hub_if.master).
module sensor_hub #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] threshold,
    input  logic              overflow_clr,
    output logic [NUM_CH-1:0] overflow,
    sensor_hub_if.master      bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = DATA_W + AVG_LOG2;
    // Keep a 1-bit counter in pass-through mode; it simply never leaves zero.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]  r_acc       [NUM_CH];
    logic [CNT_W-1:0]  r_cnt       [NUM_CH];
    logic [DATA_W-1:0] r_pend_data [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_ovf;
    logic [CH_W-1:0]   r_last;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic              r_out_alarm;
    logic              r_out_valid;

    logic [DATA_W-1:0] w_sample [NUM_CH];
    logic [ACC_W-1:0]  w_sum    [NUM_CH];
    logic [DATA_W-1:0] w_result [NUM_CH];
    logic [NUM_CH-1:0] w_done;
    logic [NUM_CH-1:0] w_gnt_oh;
    logic              w_load_op;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [DATA_W-1:0] w_gnt_data;
    int                w_best;

    // Per-channel datapath. The accumulator is sized so that 2^AVG_LOG2 full-scale
    // samples fit exactly, so the running sum cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sample[i] = bus.sensor_input[i*DATA_W +: DATA_W];
            w_sum[i]    = r_acc[i] + ACC_W'(w_sample[i]);
            w_result[i] = w_sum[i][AVG_LOG2 +: DATA_W];
            w_done[i]   = enable && bus.sensor_valid[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    // Round-robin pick: the pending channel with the smallest circular distance
    // past the last grant wins.
    assign w_load_op = !r_out_valid || bus.out_ready;

    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        w_best     = NUM_CH;
        for (int j = 0; j < NUM_CH; j++) begin
            if (r_pend[j] && (((j - int'(r_last) - 1 + 2*NUM_CH) % NUM_CH) < w_best)) begin
                w_best     = (j - int'(r_last) - 1 + 2*NUM_CH) % NUM_CH;
                w_gnt_vld  = 1'b1;
                w_gnt_idx  = CH_W'(j);
                w_gnt_data = r_pend_data[j];
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            w_gnt_oh[j] = w_load_op && w_gnt_vld && (w_gnt_idx == CH_W'(j));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]       <= '0;
                r_cnt[i]       <= '0;
                r_pend_data[i] <= '0;
            end
            r_pend      <= '0;
            r_ovf       <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_alarm <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Dropping enable discards any partial average.
                if (!enable) begin
                    r_acc[i] <= '0;
                    r_cnt[i] <= '0;
                end else if (bus.sensor_valid[i]) begin
                    if (w_done[i]) begin
                        r_acc[i] <= '0;
                        r_cnt[i] <= '0;
                    end else begin
                        r_acc[i] <= w_sum[i];
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end

                // A new result always lands in the slot; it only counts as lost
                // if the previous one is still sitting there un-granted.
                if (w_done[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_pend_data[i] <= w_result[i];
                end else if (w_gnt_oh[i]) begin
                    r_pend[i] <= 1'b0;
                end

                // Set beats clear in the same cycle.
                if (w_done[i] && r_pend[i] && !w_gnt_oh[i]) begin
                    r_ovf[i] <= 1'b1;
                end else if (overflow_clr) begin
                    r_ovf[i] <= 1'b0;
                end
            end

            if (w_load_op && w_gnt_vld) begin
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                r_out_alarm <= (w_gnt_data >= threshold);
                r_out_valid <= 1'b1;
                r_last      <= w_gnt_idx;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_alarm = r_out_alarm;
    assign bus.out_valid = r_out_valid;
    assign overflow      = r_ovf;
endmodule

// File: doc/sensor_hub.md
Name: sensor_hub

Overview:
Parametrised multi-channel successor to the single-channel sensor front end. It accepts NUM_CH independent sensor sample streams and decimates each one by block-averaging 2^AVG_LOG2 samples. Completed averages are merged onto one valid/ready output stream through a round-robin arbiter, and each result carries a threshold alarm flag. It sits between the per-sensor interface logic and the downstream data processor.

Parameters:
NUM_CH, 4, number of sensor channels (>=1)
DATA_W, 8, sample and result width in bits
AVG_LOG2, 2, log2 of samples averaged per result (0 = pass-through, each sample is a result)
CH_W, max(1,$clog2(NUM_CH)), width of channel index (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  acquisition enable
sensor_input  in  NUM_CH*DATA_W  packed samples, channel i at bits [i*DATA_W +: DATA_W]
sensor_valid  in  NUM_CH  per-channel sample strobe
threshold  in  DATA_W  alarm threshold (unsigned)
out_data  out  DATA_W  averaged result
out_ch  out  CH_W  source channel of out_data
out_alarm  out  1  out_data >= threshold
out_valid  out  1  output stream valid
out_ready  in  1  downstream ready
overflow  out  NUM_CH  sticky per-channel result-lost flag
overflow_clr  in  1  clears all overflow bits

Behaviour:
- Reset (reset_n low, async): all outputs 0; accumulators, counters, pending flags and arbiter pointer (last_grant = NUM_CH-1) cleared.
- Per-channel accumulator: width DATA_W+AVG_LOG2; sample counter: AVG_LOG2 bits. All arithmetic unsigned; the accumulator never wraps.
- Sample accept: a sample is accepted when enable && sensor_valid[i]. Samples arriving while enable is low are ignored.
- enable low: clears every accumulator and counter, so partial averages are discarded. Pending results and the output register still drain normally.
- Completion: the accepted sample with counter == 2^AVG_LOG2-1 completes an average.
  - result = (acc + sample) >> AVG_LOG2, truncated.
  - result is written to pend_data[i] and sets pend[i].
  - acc and counter return to 0 on the same edge.
- Per-channel buffer: one pending slot per channel.
  - If pend[i] is already set and is not granted on the same edge, the new result overwrites it and overflow[i] sets.
  - If pend[i] is granted on the same edge, the new result refills it and overflow does not set.
- Output register: a load opportunity exists when out_valid==0 || out_ready.
  - On a load opportunity, grant the first set pend[] bit searching from last_grant+1 upward, modulo NUM_CH.
  - Grant loads out_data, out_ch, out_alarm (compared against threshold as it is that cycle), sets out_valid, clears pend[granted] unless refilled, and updates last_grant.
  - If nothing is pending and out_ready is high, out_valid drops.
- Backpressure: while out_valid && !out_ready, out_data, out_ch and out_alarm hold stable.
- Latency: the final sample is accepted at edge E; pend is set after E; out_valid is high after edge E+1 (2 cycles), provided the output is free.
- Throughput: one result per cycle with out_ready held high.
- overflow_clr: clears all overflow bits. A set event in the same cycle wins for that bit.

Test Plan:
(NUM_CH=4, DATA_W=8, AVG_LOG2=2, out_ready=1 unless stated.)
1. Single-channel average: ch0 samples 10,20,30,41 on consecutive cycles, threshold=20 -> two cycles after the 4th sample: one out_valid pulse with out_data=25, out_ch=0, out_alarm=1. Repeat with threshold=26 -> out_alarm=0.
2. Round-robin order: all four channels complete on the same edge with averages 1,2,3,4 -> four consecutive out_valid beats, out_ch 0,1,2,3. A second simultaneous completion starts again at ch0 (last_grant=3).
3. Backpressure and overflow: out_ready=0 while ch1 completes averages 5, 6, 7 -> out_data=5 held stable, overflow[1]=1. After out_ready=1: beats 5 then 7 (6 lost). overflow_clr pulse -> overflow=0.
4. Full-scale input: ch2 samples 255 x4 -> out_data=255 (no wrap), out_alarm=1 with threshold=255.
5. Enable drop: ch3 samples 100,100, then enable=0 for 1 cycle, then ch3 samples 8 x4 -> exactly one result, out_data=8.
6. Reset mid-operation: assert reset_n=0 while out_valid=1 and a partial accumulation is in progress -> out_valid, overflow and out_data go to 0 immediately without a clock edge. After release, the next four samples of 12 give out_data=12.
